// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-master memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 32;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  // Down-counter must hold READ_LATENCY; never narrower than one bit.
  function automatic int unsigned lat_cnt_width(input int unsigned read_latency);
    return (read_latency < 2) ? 1 : $clog2(read_latency + 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin pick between two requesters; a tie goes to the one not served last.
module mem_arb_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_o
);

  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_o       = (req0_i & req1_i) ? ~last_grant_i : req1_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-memory port between two req/ack masters, one access in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_write_en_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_ack_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_write_en_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_ack_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_write_en_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam int unsigned       CNT_W       = lat_cnt_width(READ_LATENCY);
  localparam logic [CNT_W-1:0]  RD_CNT_INIT = CNT_W'(READ_LATENCY);

  arb_state_e            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  op_we_q, op_we_d;
  logic                  mem_we_q, mem_we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  pick_valid, pick_grant;
  logic                  sel_we;

  mem_arb_rr_pick u_pick (
    .req0_i        (m0_req_i),
    .req1_i        (m1_req_i),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (pick_valid),
    .grant_o       (pick_grant)
  );

  assign sel_we = pick_grant ? m1_write_en_i : m0_write_en_i;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_we_d      = op_we_q;
    mem_we_d     = 1'b0;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_ACCESS;
          grant_d      = pick_grant;
          last_grant_d = pick_grant;
          op_we_d      = sel_we;
          mem_we_d     = sel_we;
          addr_d       = pick_grant ? m1_addr_i : m0_addr_i;
          wdata_d      = pick_grant ? m1_data_i : m0_data_i;
          // Writes need one ACCESS cycle, reads READ_LATENCY+1.
          cnt_d        = sel_we ? '0 : RD_CNT_INIT;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!op_we_q) begin
            if (grant_q) m1_rdata_d = mem_data_i;
            else         m0_rdata_d = mem_data_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_we_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_we_q      <= op_we_d;
      mem_we_q     <= mem_we_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign m0_ack_o       = (state_q == ST_DONE) && !grant_q;
  assign m1_ack_o       = (state_q == ST_DONE) &&  grant_q;
  assign m0_data_o      = m0_rdata_q;
  assign m1_data_o      = m1_rdata_q;
  assign mem_addr_o     = addr_q;
  assign mem_write_en_o = mem_we_q;
  assign mem_data_o     = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a latency/round-robin model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m1_ack, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  // Reference model state
  logic        model_last;
  logic [31:0] model_hold [2];
  logic [31:0] ref_mem [int unsigned];

  mem_port_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .READ_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req_i       (m0_req),
    .m0_addr_i      (m0_addr),
    .m0_write_en_i  (m0_we),
    .m0_data_i      (m0_wdata),
    .m0_ack_o       (m0_ack),
    .m0_data_o      (m0_rdata),
    .m1_req_i       (m1_req),
    .m1_addr_i      (m1_addr),
    .m1_write_en_i  (m1_we),
    .m1_data_i      (m1_wdata),
    .m1_ack_o       (m1_ack),
    .m1_data_o      (m1_rdata),
    .mem_addr_o     (mem_addr),
    .mem_write_en_o (mem_we),
    .mem_data_o     (mem_wdata),
    .mem_data_i     (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural word memory with LAT-cycle read pipeline
  logic [31:0] phys_mem [int unsigned];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= phys_mem.exists(mem_addr >> 2) ? phys_mem[mem_addr >> 2] : 32'h0;
    if (mem_we) phys_mem[mem_addr >> 2] = mem_wdata;
  end
  assign mem_rdata = rd_pipe[LAT-1];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
  endfunction

  function automatic int unsigned exp_lat(input logic we);
    return we ? 2 : 2 + LAT;
  endfunction

  function automatic logic get_ack(input int unsigned m);
    return (m == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic [31:0] get_data(input int unsigned m);
    return (m == 0) ? m0_rdata : m1_rdata;
  endfunction

  task automatic drive(input int unsigned m, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic model_reset();
    model_last    = 1'b1;
    model_hold[0] = '0;
    model_hold[1] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_mem_side: got we=%0b addr=%h data=%h, want all 0", mem_we, mem_addr, mem_wdata);
    end
    n_tests++;
    if ({m0_ack, m1_ack, m0_rdata, m1_rdata} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_master_side: got ack=%0b%0b d0=%h d1=%h, want all 0", m0_ack, m1_ack, m0_rdata, m1_rdata);
    end
    tick();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_write_read();
    logic        we_t [2];
    logic [31:0] wd;
    int unsigned t0, d;
    bit          got;
    we_t[0] = 1'b1;
    we_t[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      wd = we_t[i] ? 32'hDEADBEEF : $urandom;
      drive(0, 1'b1, we_t[i], 32'h100, wd);
      t0  = cyc;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        d = cyc - t0;
        if (d == 1) begin
          n_tests++;
          if ({mem_we, mem_addr} !== {we_t[i], 32'h100} || (we_t[i] && mem_wdata !== wd)) begin
            n_fail++;
            $display("FAIL wr_rd_strobe[%0d]: got we=%0b addr=%h data=%h, want we=%0b addr=100 data=%h", i, mem_we, mem_addr, mem_wdata, we_t[i], wd);
          end
        end
        if (d >= 2) begin
          n_tests++;
          if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rd_strobe_len[%0d]: got we=%0b at cycle %0d, want 0", i, mem_we, d);
          end
        end
        if (m0_ack || m1_ack) begin
          got = 1;
          n_tests++;
          if (!m0_ack || m1_ack || d != exp_lat(we_t[i])) begin
            n_fail++;
            $display("FAIL wr_rd_ack[%0d]: got ack0=%0b ack1=%0b at cycle %0d, want ack0 at %0d", i, m0_ack, m1_ack, d, exp_lat(we_t[i]));
          end
        end
      end
      if (!got) begin
        n_tests++; n_fail++;
        $display("FAIL wr_rd_timeout[%0d]: got no ack, want ack", i);
      end
      if (we_t[i]) ref_mem[32'h100 >> 2] = wd;
      else         model_hold[0] = ref_rd(32'h100);
      model_last = 1'b0;
      n_tests++;
      if (m0_rdata !== model_hold[0]) begin
        n_fail++;
        $display("FAIL wr_rd_data[%0d]: got %h, want %h", i, m0_rdata, model_hold[0]);
      end
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      n_tests++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h100 || m0_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_rd_hold[%0d]: got we=%0b addr=%h ack=%0b, want 0/100/0", i, mem_we, mem_addr, m0_ack);
      end
    end
  endtask

  task automatic test_tie_out_of_reset();
    int unsigned t0, exp0, exp1;
    bit          got0, got1;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive(1, 1'b1, 1'b1, 32'h200, 32'h12345678);
    t0   = cyc;
    exp0 = t0 + exp_lat(1'b0);
    exp1 = exp0 + 1 + exp_lat(1'b1);
    got0 = 0;
    got1 = 0;
    for (int k = 0; k < 30 && !got1; k++) begin
      @(negedge clk);
      if (m0_ack) begin
        got0 = 1;
        n_tests++;
        if (cyc != exp0 || m0_rdata !== ref_rd(32'h100)) begin
          n_fail++;
          $display("FAIL tie_m0: got ack at +%0d data=%h, want +%0d data=%h", cyc - t0, m0_rdata, exp0 - t0, ref_rd(32'h100));
        end
        model_hold[0] = ref_rd(32'h100);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (m1_ack) begin
        got1 = 1;
        n_tests++;
        if (!got0 || cyc != exp1 || m1_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL tie_m1: got ack at +%0d after_m0=%0b data=%h, want +%0d after_m0=1 data=0", cyc - t0, got0, m1_rdata, exp1 - t0);
        end
        ref_mem[32'h200 >> 2] = 32'h12345678;
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    if (!got1) begin
      n_tests++; n_fail++;
      $display("FAIL tie_timeout: got m0=%0b m1=%0b acks, want both", got0, got1);
    end
    model_last = 1'b1;
    tick();
    drive(0, 1'b1, 1'b0, 32'h200, 32'h0);
    t0   = cyc;
    got0 = 0;
    for (int k = 0; k < 20 && !got0; k++) begin
      @(negedge clk);
      if (m0_ack) begin
        got0 = 1;
        n_tests++;
        if (cyc - t0 != exp_lat(1'b0) || m0_rdata !== 32'h12345678 || m1_rdata !== model_hold[1]) begin
          n_fail++;
          $display("FAIL cross_read: got +%0d d0=%h d1=%h, want +%0d d0=12345678 d1=%h", cyc - t0, m0_rdata, m1_rdata, exp_lat(1'b0), model_hold[1]);
        end
      end
    end
    if (!got0) begin
      n_tests++; n_fail++;
      $display("FAIL cross_read_timeout: got no ack, want m0 ack");
    end
    model_hold[0] = 32'h12345678;
    model_last    = 1'b0;
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Both masters request continuously; service must alternate with fixed spacing.
  task automatic test_back_to_back(input int unsigned per_master);
    logic        we_t [2][8];
    logic [31:0] ad_t [2][8];
    logic [31:0] wd_t [2][8];
    int unsigned idx [2];
    int unsigned done_n, exp_ack, k;
    int unsigned m, o;
    logic        exp_m;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) begin
        we_t[i][j] = $urandom_range(0, 1) == 1;
        ad_t[i][j] = 32'h400 + ($urandom_range(0, 7) << 2);
        wd_t[i][j] = $urandom;
      end
      idx[i] = 0;
    end
    tick();
    drive(0, 1'b1, we_t[0][0], ad_t[0][0], wd_t[0][0]);
    drive(1, 1'b1, we_t[1][0], ad_t[1][0], wd_t[1][0]);
    exp_m   = ~model_last;
    exp_ack = cyc + exp_lat(we_t[exp_m][0]);
    done_n  = 0;
    k       = 0;
    while (done_n < 2 * per_master && k < 200) begin
      k++;
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        m = exp_m ? 1 : 0;
        o = 1 - m;
        n_tests++;
        if ((m0_ack && m1_ack) || !get_ack(m) || cyc != exp_ack) begin
          n_fail++;
          $display("FAIL b2b_grant[%0d]: got ack0=%0b ack1=%0b at %0d, want ack%0d at %0d", done_n, m0_ack, m1_ack, cyc, m, exp_ack);
        end
        if (we_t[m][idx[m]]) ref_mem[ad_t[m][idx[m]] >> 2] = wd_t[m][idx[m]];
        else                 model_hold[m] = ref_rd(ad_t[m][idx[m]]);
        n_tests++;
        if (get_data(m) !== model_hold[m] || get_data(o) !== model_hold[o]) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got d%0d=%h d%0d=%h, want %h %h", done_n, m, get_data(m), o, get_data(o), model_hold[m], model_hold[o]);
        end
        model_last = exp_m;
        done_n++;
        idx[m]++;
        if (idx[o] < per_master) exp_m = ~exp_m;
        if (done_n < 2 * per_master)
          exp_ack = cyc + 1 + exp_lat(we_t[exp_m ? 1 : 0][idx[exp_m ? 1 : 0]]);
        tick();
        if (idx[m] < per_master) drive(m, 1'b1, we_t[m][idx[m]], ad_t[m][idx[m]], wd_t[m][idx[m]]);
        else                     drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
      end else if (cyc == exp_ack) begin
        n_tests++; n_fail++;
        $display("FAIL b2b_missing[%0d]: got no ack at %0d, want ack%0d", done_n, cyc, exp_m);
      end
    end
    if (done_n < 2 * per_master) begin
      n_tests++; n_fail++;
      $display("FAIL b2b_timeout: got %0d acks, want %0d", done_n, 2 * per_master);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_drop_mid();
    logic [31:0] a;
    int unsigned t0, acks;
    a = 32'h400 + ($urandom_range(0, 7) << 2);
    tick();
    drive(1, 1'b1, 1'b0, a, 32'h0);
    t0 = cyc;
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m1_ack) begin
        acks++;
        n_tests++;
        if (cyc - t0 != exp_lat(1'b0) || m1_rdata !== ref_rd(a)) begin
          n_fail++;
          $display("FAIL drop_mid: got ack at +%0d data=%h, want +%0d data=%h", cyc - t0, m1_rdata, exp_lat(1'b0), ref_rd(a));
        end
      end
    end
    n_tests++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL drop_mid_count: got %0d acks, want 1", acks);
    end
    model_hold[1] = ref_rd(a);
    model_last    = 1'b1;
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    bit          got;
    tick();
    drive(1, 1'b1, 1'b1, 32'h500, 32'hA5A5A5A5);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wr_pre: got we=%0b, want 1", mem_we);
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wr_strobe: got we=%0b, want 0 asynchronously", mem_we);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    model_reset();
    tick();
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({m0_ack, m1_ack, m0_rdata, m1_rdata, mem_we, mem_addr, mem_wdata} !== 131'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got ack=%0b%0b d0=%h d1=%h we=%0b addr=%h wd=%h, want all 0", m0_ack, m1_ack, m0_rdata, m1_rdata, mem_we, mem_addr, mem_wdata);
    end
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_noack: got ack=%0b%0b during reset, want 00", m0_ack, m1_ack);
      end
    end
    tick();
    rst = 1'b1;
    model_reset();
    t0  = cyc;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        got = 1;
        n_tests++;
        if (!m0_ack || cyc - t0 != exp_lat(1'b0) || m0_rdata !== ref_rd(32'h100)) begin
          n_fail++;
          $display("FAIL rst_reissue: got ack0=%0b at +%0d data=%h, want ack0 at +%0d data=%h", m0_ack, cyc - t0, m0_rdata, exp_lat(1'b0), ref_rd(32'h100));
        end
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL rst_reissue_timeout: got no ack, want m0 ack");
    end
    model_hold[0] = ref_rd(32'h100);
    model_last    = 1'b0;
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_tie_out_of_reset();
    test_back_to_back(3);
    test_back_to_back(6);
    test_drop_mid();
    test_reset_mid();
    test_back_to_back(4);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
